// File: rtl/video_overlay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_overlay_pkg
//  Purpose  : Shared video types and constants for the overlay/sprite blocks.
//             Provides the RGB888 pixel type, the default coordinate width
//             and the blank-edge encoding ({previous, current}) used to
//             detect blanking transitions.
//  Revision : 1.0 - initial release
// ============================================================================
package video_overlay_pkg;

  typedef logic [23:0] rgb888_t;

  localparam int COORD_WIDTH_DEFAULT = 11;

  // Blank edge encoding: {previous sample, current sample}
  localparam logic [1:0] BLANK_FALL = 2'b10;
  localparam logic [1:0] BLANK_RISE = 2'b01;

  function automatic logic [1:0] blank_edge(input logic prev, input logic cur);
    return {prev, cur};
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_overlay_palette.sv
`default_nettype none
// ============================================================================
//  Module   : video_overlay_palette
//  Purpose  : Synchronous read-first palette RAM, one write port and one
//             read port. A write to the address being read in the same cycle
//             returns the previous contents.
//  Ports    : clock_i    - clock
//             wr_en_i    - write strobe
//             wr_addr_i  - write address
//             wr_data_i  - write RGB888 colour
//             rd_addr_i  - read address (sampled every cycle)
//             rd_data_o  - registered read data, one cycle after rd_addr_i
//  Revision : 1.0 - initial release
// ============================================================================
module video_overlay_palette
  import video_overlay_pkg::*;
#(
  parameter int PALETTE_BITS = 4
) (
  input  logic                    clock_i,
  input  logic                    wr_en_i,
  input  logic [PALETTE_BITS-1:0] wr_addr_i,
  input  rgb888_t                 wr_data_i,
  input  logic [PALETTE_BITS-1:0] rd_addr_i,
  output rgb888_t                 rd_data_o
);

  // Not reset: contents survive reset. The zero power-up state comes from
  // the device's RAM configuration defaults.
  rgb888_t mem_q [2**PALETTE_BITS];
  rgb888_t rd_data_q;

  // Read and write in one process so the read sees the pre-write value.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/video_overlay_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : video_overlay_mixer
//  Purpose  : Consumer end of the sprite overlay interface. Generates overlay
//             x/y, samples the overlay index/mask in the same cycle, resolves
//             the index through a writable palette and composites it over the
//             background stream with a 2-cycle pipeline. Keeps per-frame
//             opaque-pixel statistics.
//  Ports    : i_clock, i_reset_n            - clock, async active-low reset
//             i_video_hblank/vblank/data    - background timing and RGB
//             o_overlay_x/y/hblank/vblank   - coordinates/timing to sprites
//             i_overlay_data/mask           - sprite answer for current x/y
//             i_pal_write/index/color       - palette write port
//             i_hit_clear                   - clears sticky hit flag
//             o_video_data/hblank/vblank    - composited stream (2 cycles)
//             o_hit, o_hit_count            - hit statistics
//  Revision : 1.0 - initial release
// ============================================================================
module video_overlay_mixer
  import video_overlay_pkg::*;
#(
  parameter int PALETTE_BITS = 4,
  parameter int COORD_WIDTH  = COORD_WIDTH_DEFAULT
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_video_hblank,
  input  logic                    i_video_vblank,
  input  logic [23:0]             i_video_data,
  output logic [COORD_WIDTH-1:0]  o_overlay_x,
  output logic [COORD_WIDTH-1:0]  o_overlay_y,
  output logic                    o_overlay_hblank,
  output logic                    o_overlay_vblank,
  input  logic [7:0]              i_overlay_data,
  input  logic                    i_overlay_mask,
  input  logic                    i_pal_write,
  input  logic [PALETTE_BITS-1:0] i_pal_index,
  input  logic [23:0]             i_pal_color,
  input  logic                    i_hit_clear,
  output logic [23:0]             o_video_data,
  output logic                    o_video_hblank,
  output logic                    o_video_vblank,
  output logic                    o_hit,
  output logic [15:0]             o_hit_count
);

  // Edge history; valid_q masks the first cycle after reset so that a stale
  // reset value in the history registers is never read as an edge.
  logic valid_q, hb_prev_q, vb_prev_q;
  // Set at the first line start after reset; until then output is blanked.
  logic sync_q;

  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;

  // Stage 1
  rgb888_t bg1_q;
  logic    act1_q, opq1_q, hb1_q, vb1_q;
  // Stage 2
  rgb888_t data2_q;
  logic    hb2_q, vb2_q;

  logic        hit_q;
  logic [15:0] cnt_q, hit_count_q;

  logic                    w_hb_fall, w_hb_rise, w_vb_rise;
  logic                    w_line_ok, w_active, w_opaque;
  logic [PALETTE_BITS-1:0] w_index;
  rgb888_t                 w_pal_color;

  assign w_index   = i_overlay_data[PALETTE_BITS-1:0];
  assign w_hb_fall = valid_q && (blank_edge(hb_prev_q, i_video_hblank) == BLANK_FALL);
  assign w_hb_rise = valid_q && (blank_edge(hb_prev_q, i_video_hblank) == BLANK_RISE);
  assign w_vb_rise = valid_q && (blank_edge(vb_prev_q, i_video_vblank) == BLANK_RISE);

  // The line-start cycle itself is already a valid pixel, hence the OR.
  assign w_line_ok = sync_q | (w_hb_fall & ~i_video_vblank);
  assign w_active  = ~i_video_hblank & ~i_video_vblank & w_line_ok;
  assign w_opaque  = w_active & i_overlay_mask & (w_index != '0);

  generate
    if (PALETTE_BITS < 8) begin : g_unused_index_bits
      logic w_unused_hi;
      assign w_unused_hi = ^i_overlay_data[7:PALETTE_BITS];
    end
  endgenerate

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_video_hblank) begin
      x_d = '0;
    end else if (w_active) begin
      x_d = x_q + 1'b1;
    end
    if (i_video_vblank) begin
      y_d = '0;
    end else if (w_hb_rise) begin
      y_d = y_q + 1'b1;
    end
  end

  // Coordinates read as 0 in the blanking cycles themselves, not just after.
  assign o_overlay_x      = i_video_hblank ? '0 : x_q;
  assign o_overlay_y      = i_video_vblank ? '0 : y_q;
  assign o_overlay_hblank = i_video_hblank;
  assign o_overlay_vblank = i_video_vblank;

  video_overlay_palette #(
    .PALETTE_BITS(PALETTE_BITS)
  ) u_palette (
    .clock_i   (i_clock),
    .wr_en_i   (i_pal_write),
    .wr_addr_i (i_pal_index),
    .wr_data_i (i_pal_color),
    .rd_addr_i (w_index),
    .rd_data_o (w_pal_color)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q     <= 1'b0;
      hb_prev_q   <= 1'b0;
      vb_prev_q   <= 1'b0;
      sync_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      bg1_q       <= '0;
      act1_q      <= 1'b0;
      opq1_q      <= 1'b0;
      hb1_q       <= 1'b1;
      vb1_q       <= 1'b1;
      data2_q     <= '0;
      hb2_q       <= 1'b1;
      vb2_q       <= 1'b1;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      hit_count_q <= '0;
    end else begin
      valid_q   <= 1'b1;
      hb_prev_q <= i_video_hblank;
      vb_prev_q <= i_video_vblank;
      if (w_hb_fall && !i_video_vblank) begin
        sync_q <= 1'b1;
      end
      x_q <= x_d;
      y_q <= y_d;

      // Stage 1: palette read is launched by the same edge (inside u_palette).
      bg1_q  <= i_video_data;
      act1_q <= w_active;
      opq1_q <= w_opaque;
      hb1_q  <= i_video_hblank | ~w_line_ok;
      vb1_q  <= i_video_vblank;

      // Stage 2
      data2_q <= act1_q ? (opq1_q ? w_pal_color : bg1_q) : '0;
      hb2_q   <= hb1_q;
      vb2_q   <= vb1_q;

      // Vblank forces non-active, so latch/clear never races an increment.
      if (w_vb_rise) begin
        hit_count_q <= cnt_q;
        cnt_q       <= '0;
      end else if (w_opaque && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (w_opaque) begin
        hit_q <= 1'b1;
      end else if (i_hit_clear) begin
        hit_q <= 1'b0;
      end
    end
  end

  assign o_video_data   = data2_q;
  assign o_video_hblank = hb2_q;
  assign o_video_vblank = vb2_q;
  assign o_hit          = hit_q;
  assign o_hit_count    = hit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_video_overlay_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_overlay_mixer
//  Purpose  : Self-checking bench for video_overlay_mixer. A table of single
//             line scenarios plus hand-written sequences for coordinates,
//             read-first palette, hit statistics, saturation and mid-line
//             reset. The sprite is modelled combinationally from o_overlay_x/y.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_overlay_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hb, vb;
  logic [23:0] bg;
  logic [10:0] ox, oy;
  logic        ohb, ovb;
  logic [7:0]  ov_data;
  logic        ov_mask;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_col;
  logic        hit_clr;
  logic [23:0] vdata;
  logic        vhb, vvb, hit;
  logic [15:0] hitcnt;

  // Sprite model: rectangular region, fixed index
  logic        spr_en;
  logic [10:0] spr_xlo, spr_xhi, spr_ylo, spr_yhi;
  logic [7:0]  spr_idx;

  assign ov_mask = spr_en && (ox >= spr_xlo) && (ox <= spr_xhi) &&
                   (oy >= spr_ylo) && (oy <= spr_yhi);
  assign ov_data = spr_idx;

  video_overlay_mixer #(.PALETTE_BITS(4), .COORD_WIDTH(11)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_video_hblank   (hb),
    .i_video_vblank   (vb),
    .i_video_data     (bg),
    .o_overlay_x      (ox),
    .o_overlay_y      (oy),
    .o_overlay_hblank (ohb),
    .o_overlay_vblank (ovb),
    .i_overlay_data   (ov_data),
    .i_overlay_mask   (ov_mask),
    .i_pal_write      (pal_we),
    .i_pal_index      (pal_idx),
    .i_pal_color      (pal_col),
    .i_hit_clear      (hit_clr),
    .o_video_data     (vdata),
    .o_video_hblank   (vhb),
    .o_video_vblank   (vvb),
    .o_hit            (hit),
    .o_hit_count      (hitcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    hb = 1'b1;
    repeat (n) step();
  endtask

  task automatic run_line(input int len, input bit clr);
    hb      = 1'b1;
    hit_clr = clr;
    step();
    hit_clr = 1'b0;
    repeat (3) step();
    hb = 1'b0;
    repeat (len) step();
    hb = 1'b1;
  endtask

  task automatic pal_write(input logic [3:0] i, input logic [23:0] c);
    pal_we  = 1'b1;
    pal_idx = i;
    pal_col = c;
    step();
    pal_we  = 1'b0;
  endtask

  // Capture of active output pixels
  logic [23:0] capq[$];
  bit          cap_en = 1'b0;
  always @(negedge clk) begin
    if (cap_en && !vhb && !vvb) capq.push_back(vdata);
  end

  typedef struct {
    logic [23:0] bg;
    logic [7:0]  idx;
    logic [23:0] color;
    logic        mask;
    logic [10:0] xlo, xhi;
    int          exp_npal;
    logic        exp_hit;
  } vec_t;

  vec_t        vecs[7];
  logic [23:0] outv[20];

  initial begin
    int npal, nbad;
    logic [23:0] e;

    vecs[0] = '{24'h00FF00, 8'h02, 24'hFF0000, 1'b1, 11'd16, 11'd31, 16, 1'b1};
    vecs[1] = '{24'h123456, 8'h00, 24'hFFFFFF, 1'b1, 11'd16, 11'd31,  0, 1'b0};
    vecs[2] = '{24'h00FF00, 8'h02, 24'hFF0000, 1'b0, 11'd16, 11'd31,  0, 1'b0};
    vecs[3] = '{24'h202020, 8'h12, 24'h00AA55, 1'b1, 11'd16, 11'd31, 16, 1'b1};
    vecs[4] = '{24'h202020, 8'h10, 24'h777777, 1'b1, 11'd0,  11'd47,  0, 1'b0};
    vecs[5] = '{24'h000001, 8'h0F, 24'hABCDEF, 1'b1, 11'd0,  11'd0,   1, 1'b1};
    vecs[6] = '{24'h000001, 8'h01, 24'h0F0F0F, 1'b1, 11'd47, 11'd47,  1, 1'b1};

    rst_n = 1'b1; hb = 1'b1; vb = 1'b1; bg = '0;
    pal_we = 1'b0; pal_idx = '0; pal_col = '0; hit_clr = 1'b0;
    spr_en = 1'b0; spr_idx = '0; spr_xlo = '0; spr_xhi = '0; spr_ylo = '0; spr_yhi = 11'd2047;
    #2 rst_n = 1'b0;
    repeat (3) step();

    // ---- Reset state
    chk("rst_vdata", vdata, 24'h0);
    chk("rst_vhblank", vhb, 1'b1);
    chk("rst_vvblank", vvb, 1'b1);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hitcnt", hitcnt, 16'h0);
    chk("rst_oy", oy, 11'd0);

    // ---- Coordinates
    rst_n = 1'b1;
    repeat (3) step();
    vb = 1'b0;
    repeat (2) step();
    hb = 1'b0;
    #1;
    chk("x_first", ox, 11'd0);
    chk("y_line0", oy, 11'd0);
    chk("ovl_hblank_pass", ohb, 1'b0);
    chk("ovl_vblank_pass", ovb, 1'b0);
    step();
    chk("x_second", ox, 11'd1);
    repeat (6) step();
    chk("x_eighth", ox, 11'd7);
    hb = 1'b1;
    #1;
    chk("x_in_hblank", ox, 11'd0);
    repeat (4) step();
    hb = 1'b0;
    #1;
    chk("y_line1", oy, 11'd1);
    chk("x_line1", ox, 11'd0);
    repeat (10) step();
    idle(4);

    // ---- Table-driven line scenarios
    for (int i = 0; i < 7; i++) begin
      pal_write(vecs[i].idx[3:0], vecs[i].color);
      bg      = vecs[i].bg;
      spr_en  = vecs[i].mask;
      spr_idx = vecs[i].idx;
      spr_xlo = vecs[i].xlo;
      spr_xhi = vecs[i].xhi;
      spr_ylo = 11'd0;
      spr_yhi = 11'd2047;
      capq.delete();
      cap_en = 1'b1;
      run_line(48, 1'b1);
      idle(4);
      cap_en = 1'b0;
      chk($sformatf("v%0d_npix", i), capq.size(), 48);
      npal = 0;
      nbad = 0;
      for (int k = 0; k < capq.size(); k++) begin
        e = (vecs[i].mask && vecs[i].idx[3:0] != 4'd0 &&
             k >= int'(vecs[i].xlo) && k <= int'(vecs[i].xhi)) ? vecs[i].color : vecs[i].bg;
        if (capq[k] !== e) nbad++;
        if (capq[k] === vecs[i].color) npal++;
      end
      chk($sformatf("v%0d_pixel_errs", i), nbad, 0);
      chk($sformatf("v%0d_npal", i), npal, vecs[i].exp_npal);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
    end

    // ---- Read-first palette and 2-cycle latency
    pal_write(4'd2, 24'hFF0000);
    bg = 24'h00FF00; spr_en = 1'b1; spr_idx = 8'h02; spr_xlo = 11'd10; spr_xhi = 11'd11;
    idle(4);
    for (int k = 0; k < 20; k++) begin
      hb      = 1'b0;
      pal_we  = (k == 10);
      pal_idx = 4'd2;
      pal_col = 24'h0000FF;
      #1;
      outv[k] = vdata;
      step();
    end
    pal_we = 1'b0;
    idle(4);
    chk("rf_before", outv[11], 24'h00FF00);
    chk("rf_old_color", outv[12], 24'hFF0000);
    chk("rf_new_color", outv[13], 24'h0000FF);
    chk("rf_after", outv[14], 24'h00FF00);

    // ---- 16x16 block per frame
    vb = 1'b1; idle(4);
    vb = 1'b0; idle(2);
    pal_write(4'd2, 24'hFF0000);
    spr_en = 1'b1; spr_idx = 8'h02; spr_xlo = 11'd16; spr_xhi = 11'd31;
    spr_ylo = 11'd0; spr_yhi = 11'd15;
    for (int l = 0; l < 18; l++) run_line(48, 1'b0);
    idle(4);
    vb = 1'b1;
    idle(3);
    chk("hitcnt_256", hitcnt, 16'd256);
    chk("hit_set", hit, 1'b1);
    hit_clr = 1'b1;
    step();
    hit_clr = 1'b0;
    chk("hit_cleared", hit, 1'b0);

    // Clear coinciding with the only opaque pixel of the line
    vb = 1'b0; idle(3);
    spr_xlo = 11'd20; spr_xhi = 11'd20; spr_ylo = 11'd0; spr_yhi = 11'd2047;
    for (int k = 0; k < 48; k++) begin
      hb      = 1'b0;
      hit_clr = (k == 20);
      step();
      if (k == 19) chk("hit_before_set", hit, 1'b0);
      if (k == 20) chk("hit_set_wins", hit, 1'b1);
    end
    hit_clr = 1'b0;
    idle(4);

    // ---- Saturation and x wrap in one very long line
    vb = 1'b1; idle(3);
    vb = 1'b0; idle(3);
    spr_xlo = 11'd0; spr_xhi = 11'd2047;
    hb = 1'b0;
    for (int k = 0; k < 65540; k++) begin
      if (k == 2047) chk("x_max", ox, 11'd2047);
      if (k == 2048) chk("x_wrap", ox, 11'd0);
      step();
    end
    idle(4);
    vb = 1'b1;
    idle(3);
    chk("hitcnt_sat", hitcnt, 16'hFFFF);

    // ---- Reset asserted mid-line at x=100
    vb = 1'b0; idle(3);
    hb = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("pre_rst_x", ox, 11'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vdata", vdata, 24'h0);
    chk("mid_rst_vhblank", vhb, 1'b1);
    chk("mid_rst_vvblank", vvb, 1'b1);
    chk("mid_rst_hit", hit, 1'b0);
    chk("mid_rst_hitcnt", hitcnt, 16'h0);
    chk("mid_rst_x", ox, 11'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("unsync_x", ox, 11'd0);
    chk("unsync_vhblank", vhb, 1'b1);
    chk("unsync_vdata", vdata, 24'h0);
    hb = 1'b1;
    repeat (3) step();
    hb = 1'b0;
    #1;
    chk("resync_x0", ox, 11'd0);
    step();
    chk("resync_x1", ox, 11'd1);
    step();
    chk("resync_vhblank", vhb, 1'b0);
    chk("resync_vdata", vdata, 24'hFF0000);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_overlay_mixer.md
Name: video_overlay_mixer

Overview:
Consumer end of the sprite overlay interface.
- Generates the overlay pixel coordinates (o_overlay_x/o_overlay_y) that sprite generators evaluate combinationally.
- Accepts the returned overlay data/mask in the same cycle and resolves it through a small writable palette.
- Composites the result over the background RGB pixel stream.
- Sits between the video timing/background source and the video output encoder, and exposes per-frame overlay hit statistics to the CPU.

Parameters:
PALETTE_BITS, 4, palette index width; uses i_overlay_data[PALETTE_BITS-1:0], giving 2**PALETTE_BITS entries.
COORD_WIDTH, 11, width of the overlay x/y coordinate counters.

Ports:
i_clock  in  1  system/pixel clock
i_reset_n  in  1  asynchronous active-low reset
i_video_hblank  in  1  background horizontal blank
i_video_vblank  in  1  background vertical blank
i_video_data  in  24  background RGB888 pixel, valid when both blanks are low
o_overlay_x  out  COORD_WIDTH  x of the current active pixel, to sprites
o_overlay_y  out  COORD_WIDTH  y of the current line, to sprites
o_overlay_hblank  out  1  i_video_hblank passed through combinationally, to sprites
o_overlay_vblank  out  1  i_video_vblank passed through combinationally, to sprites
i_overlay_data  in  8  overlay colour index for the current o_overlay_x/y
i_overlay_mask  in  1  overlay pixel present
i_pal_write  in  1  palette write strobe
i_pal_index  in  PALETTE_BITS  palette write address
i_pal_color  in  24  palette write RGB888
i_hit_clear  in  1  clear the sticky hit flag
o_video_data  out  24  composited RGB
o_video_hblank  out  1  hblank delayed to match o_video_data
o_video_vblank  out  1  vblank delayed to match o_video_data
o_hit  out  1  sticky: at least one opaque overlay pixel drawn
o_hit_count  out  16  opaque overlay pixels in the last completed frame

Behaviour:
- Reset (async, i_reset_n=0):
  - Counters, pipeline registers, o_video_data, o_hit and o_hit_count are 0.
  - o_video_hblank and o_video_vblank are 1.
  - Palette contents are unaffected by reset and are initialised to 0 at configuration.
- Coordinate counters:
  - x is 0 while hblank=1 and increments after each active cycle (hblank=0, vblank=0), so the first active pixel of a line presents x=0.
  - y is 0 while vblank=1 and increments by 1 on each hblank rising edge outside vblank. The y for a line is therefore stable from that line's hblank falling edge, which is the sprite line_start cycle.
  - Both counters wrap modulo 2**COORD_WIDTH.
- Overlay sampling: i_overlay_data/i_overlay_mask are sampled in the same cycle as the o_overlay_x/y they answer, with zero added sprite latency.
- Opacity: a pixel is opaque iff mask=1, index != 0 and the pixel is active. Index 0 is transparent even when mask=1.
- Pipeline, 2 cycles from i_video_* to o_video_*:
  - Stage 1 registers background, index, opaque flag and blanks, and performs the palette read.
  - Stage 2 selects the palette colour if opaque, otherwise the background; outputs 0 RGB while blanking.
- Palette: single write port. A write to the entry being read in the same cycle returns the old value (read-first); the new value is visible from the next read.
- Hit statistics:
  - The internal 16-bit counter increments per opaque pixel and saturates at 0xFFFF.
  - On vblank rising edge it is copied to o_hit_count and cleared. A coincident opaque pixel is impossible there, since vblank forces non-active.
  - o_hit is set by any opaque pixel.
  - i_hit_clear clears o_hit. A clear coinciding with a new opaque pixel leaves o_hit=1 (set wins).
- Reset asserted mid-line: counters restart at 0. Output is blanked until the next hblank falling edge after reset release with vblank=0.

Decomposition:
- Shared video package: rgb888_t typedef, the COORD_WIDTH default, and the blank-edge helper constant/encoding (2'b10 falling, 2'b01 rising) reused by sprite blocks.
- One natural sub-module: video_overlay_palette (synchronous read-first RAM with write port).

Test Plan:
1. Reset release, then a line with hblank falling at cycle T → o_overlay_x=0 at T, 1 at T+1; o_overlay_y=0 on the first line after vblank, 1 on the second.
2. Palette[2]=0xFF0000, background 0x00FF00, overlay mask=1/data=2 at x=16..31 → o_video_data=0xFF0000 for exactly those 16 pixels, 2 cycles late; 0x00FF00 elsewhere.
3. mask=1 with data=0 → background is passed through and o_hit stays 0.
4. Palette write to index 2 with 0x0000FF in the same cycle an index-2 pixel enters stage 1 → that pixel shows the old colour 0xFF0000; the next pixel shows 0x0000FF.
5. A 16x16 opaque block per frame → o_hit_count=256 after vblank rise; i_hit_clear pulsed alone → o_hit=0; clear coinciding with an opaque pixel → o_hit=1.
6. Assert i_reset_n=0 mid-line at x=100 → all outputs take reset values immediately; after release x restarts at 0 on the next active line.
